// File: rtl/up_down_counter_bounded_if.sv
// Signal bundle for up_down_counter_bounded: button/load controls in, count and status out.
// master drives the controls (board side); slave is the counter itself.

interface up_down_counter_bounded_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 4
);

  logic              enable_button;
  logic              up_down;
  logic [STEP_W-1:0] step;
  logic              load;
  logic [WIDTH-1:0]  load_value;
  logic [WIDTH-1:0]  init_value;
  logic [WIDTH-1:0]  count;
  logic              at_max;
  logic              at_min;
  logic              event_pulse;
  logic              limit_pulse;

  modport master (
    output enable_button,
    output up_down,
    output step,
    output load,
    output load_value,
    output init_value,
    input  count,
    input  at_max,
    input  at_min,
    input  event_pulse,
    input  limit_pulse
  );

  modport slave (
    input  enable_button,
    input  up_down,
    input  step,
    input  load,
    input  load_value,
    input  init_value,
    output count,
    output at_max,
    output at_min,
    output event_pulse,
    output limit_pulse
  );

endinterface

// File: rtl/up_down_counter_bounded.sv
// Button-driven bounded up/down counter with variable step, wrap/saturate and synchronous load.
// Define UDC_DEBOUNCE_EN to add a DB_CYCLES stability filter on the synchronised button.

module up_down_counter_bounded #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MIN_VAL   = 0,
  parameter int unsigned MAX_VAL   = 255,
  parameter int unsigned STEP_W    = 4,
  parameter int unsigned WRAP      = 1,
  parameter int unsigned DB_CYCLES = 16
) (
  input logic                     clk,
  input logic                     reset,
  up_down_counter_bounded_if.slave bus
);

  // Wide enough that count + step or count + range never overflows natively.
  localparam int unsigned AW = WIDTH + STEP_W + 1;

  localparam logic [WIDTH-1:0] MinW   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MaxW   = WIDTH'(MAX_VAL);
  localparam logic [AW-1:0]    MinA   = AW'(MIN_VAL);
  localparam logic [AW-1:0]    MaxA   = AW'(MAX_VAL);
  localparam logic [AW-1:0]    RangeA = AW'(MAX_VAL - MIN_VAL + 1);

  if (MIN_VAL >= MAX_VAL || DB_CYCLES == 0) begin : g_param_check
    $error("up_down_counter_bounded: need MIN_VAL < MAX_VAL and DB_CYCLES > 0");
  end

  function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
    if (v < MinW) return MinW;
    if (v > MaxW) return MaxW;
    return v;
  endfunction

  logic             s1_q, s2_q;
  logic             filt;
  logic             prev_q;
  logic             press;
  logic [WIDTH-1:0] count_q;
  logic             event_q, limit_q;

  logic [AW-1:0]    cnt_a, step_a, sum_a, res_a;
  logic [WIDTH-1:0] step_count;
  logic             step_limit;

`ifdef UDC_DEBOUNCE_EN
  localparam int unsigned      DbW    = $clog2(DB_CYCLES + 1);
  localparam logic [DbW-1:0]   DbLast = DbW'(DB_CYCLES - 1);

  logic           filt_q;
  logic [DbW-1:0] db_cnt_q;

  // filt_q follows s2_q only after DB_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else if (s2_q == filt_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DbLast) begin
      filt_q   <= s2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + DbW'(1);
    end
  end

  assign filt = filt_q;
`else
  assign filt = s2_q;
`endif

  assign press  = filt & ~prev_q;
  assign cnt_a  = AW'(count_q);
  assign step_a = AW'(bus.step);

  always_comb begin
    sum_a      = cnt_a + step_a;
    res_a      = sum_a;
    step_limit = 1'b0;
    if (bus.up_down) begin
      if (sum_a > MaxA) begin
        step_limit = 1'b1;
        res_a      = (WRAP != 0) ? sum_a - RangeA : MaxA;
      end
    end else begin
      res_a = cnt_a - step_a;
      if (cnt_a < MinA + step_a) begin
        step_limit = 1'b1;
        res_a      = (WRAP != 0) ? cnt_a + RangeA - step_a : MinA;
      end
    end
  end

  assign step_count = WIDTH'(res_a);

  // prev_q advances even on a load cycle, so a press coinciding with load is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      count_q <= clamp(bus.init_value);
      event_q <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      s1_q    <= bus.enable_button;
      s2_q    <= s1_q;
      prev_q  <= filt;
      event_q <= 1'b0;
      limit_q <= 1'b0;
      if (bus.load) begin
        count_q <= clamp(bus.load_value);
      end else if (press) begin
        count_q <= step_count;
        event_q <= 1'b1;
        limit_q <= step_limit;
      end
    end
  end

  assign bus.count       = count_q;
  assign bus.at_max      = (count_q == MaxW);
  assign bus.at_min      = (count_q == MinW);
  assign bus.event_pulse = event_q;
  assign bus.limit_pulse = limit_q;

endmodule

// File: tb/tb_up_down_counter_bounded.sv
// Directed bench for up_down_counter_bounded: three instances cover wrap in an offset 9-bit range,
// saturation over 0..255, and wrap over 0..9. Inputs change and outputs are sampled on negedge.

module tb_up_down_counter_bounded;

`ifdef UDC_DEBOUNCE_EN
  localparam int DbLat = 16;
`else
  localparam int DbLat = 0;
`endif
  // Negedges from button rise until the count update is visible.
  localparam int Lat = 3 + DbLat;

  logic clk;
  logic rst_a, rst_b, rst_c;
  int   vectors;
  int   miscompares;

  up_down_counter_bounded_if #(.WIDTH(9), .STEP_W(4)) if_a ();
  up_down_counter_bounded_if #(.WIDTH(8), .STEP_W(4)) if_b ();
  up_down_counter_bounded_if #(.WIDTH(8), .STEP_W(4)) if_c ();

  up_down_counter_bounded #(
    .WIDTH(9), .MIN_VAL(10), .MAX_VAL(300), .STEP_W(4), .WRAP(1), .DB_CYCLES(16)
  ) u_a (
    .clk  (clk),
    .reset(rst_a),
    .bus  (if_a)
  );

  up_down_counter_bounded #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .STEP_W(4), .WRAP(0), .DB_CYCLES(16)
  ) u_b (
    .clk  (clk),
    .reset(rst_b),
    .bus  (if_b)
  );

  up_down_counter_bounded #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .STEP_W(4), .WRAP(1), .DB_CYCLES(16)
  ) u_c (
    .clk  (clk),
    .reset(rst_c),
    .bus  (if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs_count(input int which);
    case (which)
      0:       return 32'(if_a.count);
      1:       return 32'(if_b.count);
      default: return 32'(if_c.count);
    endcase
  endfunction

  // {at_max, at_min, event_pulse, limit_pulse}
  function automatic logic [3:0] obs_flags(input int which);
    case (which)
      0:       return {if_a.at_max, if_a.at_min, if_a.event_pulse, if_a.limit_pulse};
      1:       return {if_b.at_max, if_b.at_min, if_b.event_pulse, if_b.limit_pulse};
      default: return {if_c.at_max, if_c.at_min, if_c.event_pulse, if_c.limit_pulse};
    endcase
  endfunction

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       if_a.enable_button = v;
      1:       if_b.enable_button = v;
      default: if_c.enable_button = v;
    endcase
  endtask

  task automatic set_cmd(input int which, input logic up, input logic [3:0] stp);
    case (which)
      0:       begin if_a.up_down = up; if_a.step = stp; end
      1:       begin if_b.up_down = up; if_b.step = stp; end
      default: begin if_c.up_down = up; if_c.step = stp; end
    endcase
  endtask

  task automatic count_events(input int which, input int n, output int ev);
    logic [3:0] fl;
    ev = 0;
    repeat (n) begin
      @(negedge clk);
      fl = obs_flags(which);
      if (fl[1]) ev++;
    end
  endtask

  // One full press/release; called on a negedge with the input pipeline idle.
  task automatic press(input int which, input logic up, input logic [3:0] stp,
                       input int exp_cnt, input logic exp_lim, input string tag);
    logic [3:0] fl;
    int         ev;
    set_cmd(which, up, stp);
    set_btn(which, 1'b1);
    repeat (Lat - 1) @(negedge clk);
    fl = obs_flags(which);
    check_eq({tag, "_early_evt"}, 32'(fl[1]), 0);
    @(negedge clk);
    fl = obs_flags(which);
    check_eq({tag, "_cnt"}, obs_count(which), exp_cnt);
    check_eq({tag, "_evt"}, 32'(fl[1]), 1);
    check_eq({tag, "_lim"}, 32'(fl[0]), 32'(exp_lim));
    set_btn(which, 1'b0);
    count_events(which, Lat + 1, ev);
    check_eq({tag, "_release_evts"}, ev, 0);
  endtask

  initial begin
    logic [3:0] fl;
    int         ev;
    vectors     = 0;
    miscompares = 0;
    if_a.enable_button = 0; if_a.up_down = 1; if_a.step = 1; if_a.load = 0;
    if_a.load_value = '0; if_a.init_value = 9'd5;
    if_b.enable_button = 0; if_b.up_down = 1; if_b.step = 1; if_b.load = 0;
    if_b.load_value = '0; if_b.init_value = 8'd250;
    if_c.enable_button = 0; if_c.up_down = 1; if_c.step = 1; if_c.load = 0;
    if_c.load_value = '0; if_c.init_value = 8'd2;
    rst_a = 1; rst_b = 1; rst_c = 1;

    // Reset: init below MIN clamps up to MIN.
    repeat (2) @(negedge clk);
    fl = obs_flags(0);
    check_eq("a_reset_clamp_cnt", obs_count(0), 10);
    check_eq("a_reset_clamp_atmin", 32'(fl[2]), 1);
    check_eq("a_reset_evt", 32'(fl[1]), 0);
    check_eq("a_reset_lim", 32'(fl[0]), 0);
    if_a.init_value = 9'd300;
    @(negedge clk);
    fl = obs_flags(0);
    check_eq("a_reset_cnt", obs_count(0), 300);
    check_eq("a_reset_atmax", 32'(fl[3]), 1);
    rst_a = 0; rst_b = 0; rst_c = 0;
    @(negedge clk);
    check_eq("b_reset_cnt", obs_count(1), 250);
    check_eq("c_reset_cnt", obs_count(2), 2);
    fl = obs_flags(2);
    check_eq("c_reset_atmin", 32'(fl[2]), 0);

    // Wrap in [10,300]: 300 -> 10 -> 11 -> 12.
    press(0, 1'b1, 4'd1, 10, 1'b1, "a_up1");
    fl = obs_flags(0);
    check_eq("a_up1_atmax", 32'(fl[3]), 0);
    press(0, 1'b1, 4'd1, 11, 1'b0, "a_up2");
    press(0, 1'b1, 4'd1, 12, 1'b0, "a_up3");

    // Saturation in [0,255].
    press(1, 1'b1, 4'd8, 255, 1'b1, "b_sat1");
    fl = obs_flags(1);
    check_eq("b_sat1_atmax", 32'(fl[3]), 1);
    press(1, 1'b1, 4'd8, 255, 1'b1, "b_sat2");
    press(1, 1'b0, 4'd5, 250, 1'b0, "b_down5");

    // Wrap in [0,9], step 0, wrap onto MIN.
    press(2, 1'b0, 4'd5, 7, 1'b1, "c_down5");
    fl = obs_flags(2);
    check_eq("c_down5_atmin", 32'(fl[2]), 0);
    press(2, 1'b1, 4'd0, 7, 1'b0, "c_step0");
    press(2, 1'b1, 4'd3, 0, 1'b1, "c_up3_wrap");
    fl = obs_flags(2);
    check_eq("c_up3_atmin", 32'(fl[2]), 1);

    // Load coinciding with the press cycle wins; the press is dropped.
    set_cmd(1, 1'b1, 4'd3);
    set_btn(1, 1'b1);
    repeat (Lat - 1) @(negedge clk);
    if_b.load = 1; if_b.load_value = 8'd42;
    @(negedge clk);
    if_b.load = 0;
    fl = obs_flags(1);
    check_eq("b_load_cnt", obs_count(1), 42);
    check_eq("b_load_evt", 32'(fl[1]), 0);
    count_events(1, 100, ev);
    check_eq("b_load_dropped_evts", ev, 0);
    check_eq("b_load_hold_cnt", obs_count(1), 42);
    set_btn(1, 1'b0);
    count_events(1, Lat + 1, ev);

    // Long hold: exactly one event, none on release.
    set_btn(1, 1'b1);
    count_events(1, 100, ev);
    check_eq("b_hold_evts", ev, 1);
    check_eq("b_hold_cnt", obs_count(1), 45);
    set_btn(1, 1'b0);
    count_events(1, Lat + 1, ev);
    check_eq("b_hold_release_evts", ev, 0);

`ifdef UDC_DEBOUNCE_EN
    // Glitch shorter than the debounce window is ignored.
    set_cmd(2, 1'b1, 4'd1);
    set_btn(2, 1'b1);
    repeat (5) @(negedge clk);
    set_btn(2, 1'b0);
    count_events(2, 30, ev);
    check_eq("c_glitch_evts", ev, 0);
    check_eq("c_glitch_cnt", obs_count(2), 0);
`endif

    // Reset two cycles into a press discards it.
    if_c.init_value = 8'd7;
    set_cmd(2, 1'b1, 4'd1);
    set_btn(2, 1'b1);
    repeat (2) @(negedge clk);
    rst_c = 1;
    set_btn(2, 1'b0);
    repeat (2) @(negedge clk);
    rst_c = 0;
    count_events(2, Lat + 2, ev);
    check_eq("c_rst_mid_evts", ev, 0);
    check_eq("c_rst_mid_cnt", obs_count(2), 7);

    // Button held through reset produces one event after release.
    set_btn(2, 1'b1);
    rst_c = 1;
    repeat (3) @(negedge clk);
    rst_c = 0;
    count_events(2, Lat + 2, ev);
    check_eq("c_rst_held_evts", ev, 1);
    check_eq("c_rst_held_cnt", obs_count(2), 8);
    set_btn(2, 1'b0);
    count_events(2, Lat + 1, ev);
    check_eq("c_rst_held_release_evts", ev, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
